// File: rtl/circle_plot_pkg.sv
// Shared graphics constants: default coordinate width and the screen clip window.
package circle_plot_pkg;

    localparam int unsigned CordwDefault = 16;

    // Inclusive screen bounds used by plotters that clip to the visible area.
    localparam int ClipX0Default = 0;
    localparam int ClipY0Default = 0;
    localparam int ClipX1Default = 639;
    localparam int ClipY1Default = 479;

endpackage

// File: rtl/point_clip.sv
// Combinational inclusive window compare for a signed point; shared by the plotters.
module point_clip #(
    parameter int unsigned W  = 17,
    parameter int          X0 = 0,
    parameter int          Y0 = 0,
    parameter int          X1 = 639,
    parameter int          Y1 = 479
) (
    input  logic signed [W-1:0] px_i,
    input  logic signed [W-1:0] py_i,
    output logic                inside_o
);

    localparam logic signed [W-1:0] X0W = W'(X0);
    localparam logic signed [W-1:0] Y0W = W'(Y0);
    localparam logic signed [W-1:0] X1W = W'(X1);
    localparam logic signed [W-1:0] Y1W = W'(Y1);

    always_comb begin
        inside_o = (px_i >= X0W) && (px_i <= X1W) && (py_i >= Y0W) && (py_i <= Y1W);
    end

endmodule

// File: rtl/circle_plot.sv
// Expands circle generator distance pairs into four quadrant-symmetric points.
// Optional window clipping is enabled with the CIRCLE_PLOT_CLIP_EN macro.
module circle_plot
    import circle_plot_pkg::*;
#(
    parameter int unsigned CORDW = CordwDefault
`ifdef CIRCLE_PLOT_CLIP_EN
   ,parameter int CLIP_X0 = ClipX0Default,
    parameter int CLIP_Y0 = ClipY0Default,
    parameter int CLIP_X1 = ClipX1Default,
    parameter int CLIP_Y1 = ClipY1Default
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] xc,
    input  logic signed [CORDW-1:0] yc,
    input  logic signed [CORDW-1:0] src_xa,
    input  logic signed [CORDW-1:0] src_ya,
    input  logic                    src_valid,
    input  logic                    src_done,
    output logic                    src_oe,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StP0,
        StP1,
        StP2,
        StP3
    } state_e;

    // The extra guard bit only matters when points are window-compared before truncation.
`ifdef CIRCLE_PLOT_CLIP_EN
    localparam int unsigned PW = CORDW + 1;
`else
    localparam int unsigned PW = CORDW;
`endif

    state_e                  state_q, state_d;
    logic signed [CORDW-1:0] xc_q, xc_d;
    logic signed [CORDW-1:0] yc_q, yc_d;
    logic signed [CORDW-1:0] xa_q, xa_d;
    logic signed [CORDW-1:0] ya_q, ya_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    done_lat_q, done_lat_d;

    logic signed [PW-1:0]    xc_w, yc_w, xa_w, ya_w;
    logic signed [PW-1:0]    px_w, py_w;
    logic                    in_p;
    logic                    in_win;
    logic                    advance;

    assign xc_w = PW'(xc_q);
    assign yc_w = PW'(yc_q);
    assign xa_w = PW'(xa_q);
    assign ya_w = PW'(ya_q);

    always_comb begin
        px_w = xc_w;
        py_w = yc_w;
        case (state_q)
            StP0: begin
                px_w = xc_w - xa_w;
                py_w = yc_w + ya_w;
            end
            StP1: begin
                px_w = xc_w - ya_w;
                py_w = yc_w - xa_w;
            end
            StP2: begin
                px_w = xc_w + xa_w;
                py_w = yc_w - ya_w;
            end
            StP3: begin
                px_w = xc_w + ya_w;
                py_w = yc_w + xa_w;
            end
            default: begin
                px_w = xc_w;
                py_w = yc_w;
            end
        endcase
    end

`ifdef CIRCLE_PLOT_CLIP_EN
    point_clip #(
        .W  (PW),
        .X0 (CLIP_X0),
        .Y0 (CLIP_Y0),
        .X1 (CLIP_X1),
        .Y1 (CLIP_Y1)
    ) u_point_clip (
        .px_i     (px_w),
        .py_i     (py_w),
        .inside_o (in_win)
    );
`else
    assign in_win = 1'b1;
`endif

    always_comb begin
        in_p    = (state_q == StP0) || (state_q == StP1) ||
                  (state_q == StP2) || (state_q == StP3);
        // Off-window points are skipped in one cycle without waiting for the consumer.
        advance = in_p && (oe || !in_win);
        drawing = in_p && oe && in_win;
        src_oe  = (state_q == StAccept) && src_valid;
        x       = px_w[CORDW-1:0];
        y       = py_w[CORDW-1:0];
        busy    = busy_q;
        done    = done_q;
    end

    always_comb begin
        state_d    = state_q;
        xc_d       = xc_q;
        yc_d       = yc_q;
        xa_d       = xa_q;
        ya_d       = ya_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        // A generator completion can arrive mid-point; remember it until the next accept.
        done_lat_d = done_lat_q | (src_done && (state_q != StIdle));

        case (state_q)
            StIdle: begin
                if (start) begin
                    xc_d       = xc;
                    yc_d       = yc;
                    done_lat_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StAccept;
                end
            end
            StAccept: begin
                if (src_valid) begin
                    xa_d    = src_xa;
                    ya_d    = src_ya;
                    state_d = StP0;
                end else if (done_lat_q || src_done) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            StP0: if (advance) state_d = StP1;
            StP1: if (advance) state_d = StP2;
            StP2: if (advance) state_d = StP3;
            StP3: if (advance) state_d = StAccept;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            done_lat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            done_lat_q <= done_lat_d;
            xc_q       <= xc_d;
            yc_q       <= yc_d;
            xa_q       <= xa_d;
            ya_q       <= ya_d;
        end
    end

endmodule

// File: tb/tb_circle_plot.sv
// Self-checking bench for circle_plot: vector table, hand sequences and random circles.
module tb_circle_plot;

    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic oe_man = 1'b0;
    logic oe_auto = 1'b0;
    logic oe_rnd = 1'b1;
    bit   oe_rand_mode = 1'b0;
    logic oe;
    logic src_valid = 1'b0;
    logic src_done = 1'b0;
    logic signed [CW-1:0] xc = '0;
    logic signed [CW-1:0] yc = '0;
    logic signed [CW-1:0] src_xa = '0;
    logic signed [CW-1:0] src_ya = '0;
    logic src_oe, drawing, busy, done;
    logic signed [CW-1:0] x, y;

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;
    bit rgap = 1'b0;
    logic signed [CW-1:0] qx[$];
    logic signed [CW-1:0] qy[$];
    int pq_x[$];
    int pq_y[$];

    typedef struct {
        int cx;
        int cy;
        int np;
        int ax[2];
        int ay[2];
        int ex[8];
        int ey[8];
        bit late;
    } vec_t;

    vec_t tbl[5];

    assign oe = oe_auto ? oe_rnd : oe_man;

    circle_plot #(.CORDW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .oe        (oe),
        .xc        (xc),
        .yc        (yc),
        .src_xa    (src_xa),
        .src_ya    (src_ya),
        .src_valid (src_valid),
        .src_done  (src_done),
        .src_oe    (src_oe),
        .x         (x),
        .y         (y),
        .drawing   (drawing),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            oe_rnd = oe_rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    // Every emitted point must be the next one the reference expects.
    initial begin
        logic signed [CW-1:0] ex, ey;
        forever begin
            @(negedge clk);
            if (mon_en && drawing) begin
                if (qx.size() == 0) begin
                    chk("extra_point", 32'd1, 32'd0);
                end else begin
                    ex = qx.pop_front();
                    ey = qy.pop_front();
                    chk("pt_x", x, ex);
                    chk("pt_y", y, ey);
                end
            end
        end
    end

    // Reference: the four points are the centre plus the offset (-xa, ya) rotated by 90 deg steps.
    task automatic push_model(input int cx, input int cy, input int ax, input int ay);
        int u, v, t;
        u = -ax;
        v = ay;
        for (int k = 0; k < 4; k++) begin
            qx.push_back(CW'(cx + u));
            qy.push_back(CW'(cy + v));
            t = u;
            u = -v;
            v = t;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the pair was accepted.
    task automatic feed_pair(input int ax, input int ay);
        bit ok;
        int gap;
        gap = rgap ? int'($urandom_range(0, 2)) : 0;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
        end
        src_valid = 1'b1;
        src_xa = CW'(ax);
        src_ya = CW'(ay);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (src_oe) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        src_valid = 1'b0;
    endtask

    task automatic run_circle(input int cx, input int cy, input bit late);
        int np;
        bit ok;
        np = pq_x.size();
        @(posedge clk);
        #1;
        xc = CW'(cx);
        yc = CW'(cy);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        xc = CW'($urandom);
        yc = CW'($urandom);
        for (int p = 0; p < np; p++) feed_pair(pq_x[p], pq_y[p]);
        pq_x.delete();
        pq_y.delete();
        if (!late) begin
            src_done = 1'b1;
            @(posedge clk);
            #1;
            src_done = 1'b0;
        end
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            #1;
            if (qx.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (late) src_done = 1'b1;
        @(negedge clk);
        chk("done_early", done, 1'b0);
        chk("busy_accept", busy, 1'b1);
        @(posedge clk);
        #1;
        src_done = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("busy_fall", busy, 1'b0);
        @(negedge clk);
        chk("done_one_tick", done, 1'b0);
    endtask

    initial begin
        tbl[0] = '{100, 50, 1, '{-5, 0}, '{0, 0},
                   '{105, 100, 95, 100, 0, 0, 0, 0}, '{50, 55, 50, 45, 0, 0, 0, 0}, 1'b1};
        tbl[1] = '{10, 10, 2, '{-1, 0}, '{0, 1},
                   '{11, 10, 9, 10, 10, 9, 10, 11}, '{10, 11, 10, 9, 11, 10, 9, 10}, 1'b0};
        tbl[2] = '{7, -3, 1, '{0, 0}, '{0, 0},
                   '{7, 7, 7, 7, 0, 0, 0, 0}, '{-3, -3, -3, -3, 0, 0, 0, 0}, 1'b0};
        tbl[3] = '{0, 0, 1, '{-3, 0}, '{4, 0},
                   '{3, -4, -3, 4, 0, 0, 0, 0}, '{4, 3, -4, -3, 0, 0, 0, 0}, 1'b1};
        tbl[4] = '{32767, -32768, 1, '{-1, 0}, '{1, 0},
                   '{-32768, 32766, 32766, -32768, 0, 0, 0, 0},
                   '{-32767, -32767, 32767, 32767, 0, 0, 0, 0}, 1'b0};

        // Reset state, with inputs that would otherwise provoke activity.
        rst = 1'b1;
        src_valid = 1'b1;
        oe_man = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_drawing", drawing, 1'b0);
        chk("rst_src_oe", src_oe, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_valid = 1'b0;
        oe_man = 1'b0;
        @(negedge clk);
        chk("idle_src_oe", src_oe, 1'b0);

        // Vector table, oe held high.
        mon_en = 1'b1;
        oe_auto = 1'b1;
        oe_rand_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4 * tbl[i].np; j++) begin
                qx.push_back(CW'(tbl[i].ex[j]));
                qy.push_back(CW'(tbl[i].ey[j]));
            end
            for (int p = 0; p < tbl[i].np; p++) begin
                pq_x.push_back(tbl[i].ax[p]);
                pq_y.push_back(tbl[i].ay[p]);
            end
            run_circle(tbl[i].cx, tbl[i].cy, tbl[i].late);
        end

        // Backpressure in P1/P2, ignored start mid-circle, src_done during P2.
        mon_en = 1'b0;
        oe_auto = 1'b0;
        @(posedge clk);
        #1;
        xc = 100;
        yc = 50;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_valid = 1'b1;
        src_xa = -5;
        src_ya = 0;
        oe_man = 1'b1;
        @(negedge clk);
        chk("bp_src_oe", src_oe, 1'b1);
        chk("bp_accept_nodraw", drawing, 1'b0);
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        @(negedge clk);
        chk("bp_p0_draw", drawing, 1'b1);
        chk("bp_p0_x", x, 105);
        chk("bp_p0_y", y, 50);
        chk("bp_p0_src_oe", src_oe, 1'b0);
        @(posedge clk);
        #1;
        oe_man = 1'b0;
        start = 1'b1;
        xc = 0;
        yc = 0;
        @(negedge clk);
        chk("bp_p1_hold_draw", drawing, 1'b0);
        chk("bp_p1_hold_x", x, 100);
        chk("bp_p1_hold_y", y, 55);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("bp_p1_hold2_x", x, 100);
        chk("bp_p1_hold2_y", y, 55);
        chk("bp_p1_hold2_src_oe", src_oe, 1'b0);
        @(posedge clk);
        #1;
        oe_man = 1'b1;
        @(negedge clk);
        chk("bp_p1_draw", drawing, 1'b1);
        chk("bp_p1_x", x, 100);
        chk("bp_p1_y", y, 55);
        @(posedge clk);
        #1;
        oe_man = 1'b0;
        src_done = 1'b1;
        @(negedge clk);
        chk("bp_p2_hold_draw", drawing, 1'b0);
        chk("bp_p2_hold_x", x, 95);
        chk("bp_p2_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        src_done = 1'b0;
        oe_man = 1'b1;
        @(negedge clk);
        chk("bp_p2_draw", drawing, 1'b1);
        chk("bp_p2_x", x, 95);
        chk("bp_p2_y", y, 50);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_p3_draw", drawing, 1'b1);
        chk("bp_p3_x", x, 100);
        chk("bp_p3_y", y, 45);
        chk("bp_p3_done", done, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_accept_draw", drawing, 1'b0);
        chk("bp_accept_done", done, 1'b0);
        chk("bp_accept_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_done", done, 1'b1);
        chk("bp_busy_fall", busy, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_done_tick", done, 1'b0);

        // Reset in P1.
        @(posedge clk);
        #1;
        xc = 5;
        yc = 5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src_valid = 1'b1;
        src_xa = -2;
        src_ya = 0;
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_p1_x", x, 5);
        chk("mid_p1_y", y, 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        src_valid = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_drawing", drawing, 1'b0);
        chk("mid_rst_src_oe", src_oe, 1'b0);
        @(posedge clk);
        #1;
        src_valid = 1'b0;

        // Fresh circle after the reset.
        mon_en = 1'b1;
        oe_auto = 1'b1;
        qx.delete();
        qy.delete();
        push_model(100, 50, -5, 0);
        pq_x.push_back(-5);
        pq_y.push_back(0);
        run_circle(100, 50, 1'b0);

        // Random circles against the rotation model, random oe and generator gaps.
        oe_rand_mode = 1'b1;
        rgap = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int cx, cy, np, ax, ay;
            np = int'($urandom_range(1, 4));
            if (n < 20) begin
                cx = int'($urandom_range(0, 400)) - 200;
                cy = int'($urandom_range(0, 400)) - 200;
            end else begin
                cx = int'($urandom_range(0, 65535)) - 32768;
                cy = int'($urandom_range(0, 65535)) - 32768;
            end
            for (int p = 0; p < np; p++) begin
                if (n < 20) begin
                    ax = -int'($urandom_range(0, 30));
                    ay = int'($urandom_range(0, 30));
                end else begin
                    ax = -int'($urandom_range(0, 32768));
                    ay = int'($urandom_range(0, 32767));
                end
                push_model(cx, cy, ax, ay);
                pq_x.push_back(ax);
                pq_y.push_back(ay);
            end
            run_circle(cx, cy, 1'($urandom_range(0, 1)));
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/circle_plot.md
Name: circle_plot

Overview:
- Consumer for the circle distance generator's (xa, ya) output stream.
- Expands each accepted distance pair into four quadrant-symmetric screen points around a centre.
- Points are emitted one per cycle under downstream output-enable to the framebuffer/pixel writer.
- Sits between the circle generator and the draw/pixel-write stage; the shape controller starts both together.

Parameters:
- CORDW, 16, signed coordinate width for centre, distances and output points.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  latch centre and begin a circle (honoured in IDLE only)
- oe  in  1  downstream output enable; a point is consumed in any cycle where drawing=1
- xc  in  CORDW  signed centre x (sampled on start)
- yc  in  CORDW  signed centre y (sampled on start)
- src_xa  in  CORDW  signed x distance from generator (≤0)
- src_ya  in  CORDW  signed y distance from generator (≥0)
- src_valid  in  1  generator distances valid
- src_done  in  1  generator complete (one-tick pulse)
- src_oe  out  1  accept current distances (combinational)
- x  out  CORDW  signed point x
- y  out  CORDW  signed point y
- drawing  out  1  x/y valid and consumed this cycle
- busy  out  1  circle in progress
- done  out  1  all points emitted (one-tick pulse)

Behaviour:
- Reset: state IDLE; busy=0, done=0, drawing=0, src_oe=0; x/y don't-care; src_done latch cleared. Reset overrides everything, including mid-circle.
- State machine: IDLE, ACCEPT, P0, P1, P2, P3.
- IDLE:
  - done<=0.
  - On start: latch xc/yc, clear src_done latch, busy<=1, go to ACCEPT.
- ACCEPT:
  - src_oe = src_valid, combinational.
  - If src_valid: latch xa/ya, go to P0.
  - Else if src_done latch set (or src_done this cycle): busy<=0, done<=1, go to IDLE.
- Handshake with generator: src_oe is high for exactly one cycle per accept. The generator drops src_valid the following cycle, so no double accept is possible.
- src_done latch:
  - Set whenever src_done=1 in any state other than IDLE.
  - src_done may arrive while in P0..P3; it is held until ACCEPT.
- Point formulas, computed at CORDW+1 bits then truncated (two's-complement wrap):
  - P0 = (xc-xa, yc+ya)
  - P1 = (xc-ya, yc-xa)
  - P2 = (xc+xa, yc-ya)
  - P3 = (xc+ya, yc+xa)
- Point emission, P0..P3:
  - x/y are combinational from the latched values and state.
  - drawing = oe.
  - On oe: advance P0→P1→P2→P3→ACCEPT.
  - Without oe: hold state and values.
- Latency:
  - First point is available 1 cycle after accept.
  - 4 points take 4 cycles with oe held high.
  - Minimum 5 cycles per distance pair.
- Duplicates are not suppressed:
  - r=0 yields 4× centre.
  - Axis points appear twice across pairs.
- start outside IDLE is ignored.
- done asserts the cycle after the final ACCEPT decision. busy falls in the same cycle done rises.

Optional Feature:
- Macro: CIRCLE_PLOT_CLIP_EN.
- Adds parameters CLIP_X0=0, CLIP_Y0=0, CLIP_X1=639, CLIP_Y1=479.
- With macro defined:
  - Each P-state point is compared at CORDW+1 width, before truncation, against the inclusive window.
  - Out-of-window point: drawing=0 and the state advances in one cycle regardless of oe.
  - Off-window and wrapped points are never emitted.
- Without macro: all four points are emitted as above, with no comparison logic.

Decomposition:
- Shared graphics package/header holds the CORDW default and the clip window constants (screen bounds).
- State encoding stays local.
- One natural sub-module: point_clip, a combinational window-compare on a CORDW+1 point. It is instantiated only under CIRCLE_PLOT_CLIP_EN and is reusable by line/rect plotters.

Test Plan:
- Compass points: centre (100,50), feed pair (-5,0), oe=1 → (105,50),(100,55),(95,50),(100,45) on 4 consecutive cycles; src_oe one cycle.
- Generator r0=1 closed-loop: centre (10,10), two pairs → 8 points:
  - First pair: (11,10),(10,11),(9,10),(10,9).
  - Second pair: (10,11),(9,10),(10,9),(11,10).
  - Then done one tick, busy 0.
- Backpressure: toggle oe 1/0 during P1 → same point held while oe=0; no skip or duplication; src_oe stays low.
- Late/early done: pulse src_done during P2 → remaining points emitted, then done 1 cycle after ACCEPT; r0=0 → 4× (xc,yc) then done.
- Reset mid-circle: rst in P1 → next cycle busy=0, drawing=0, src_oe=0; new start works normally.
- Clip (CIRCLE_PLOT_CLIP_EN): centre (2,2), pair (-5,0) → only (7,2),(2,7) emitted; (-3,2),(2,-3) skipped in 1 cycle each.
